vc_credit_arbiter: RTL
======================

// Module: vc_credit_arbiter
// PURPOSE
//   Output-port scheduler for one NoC link carrying the four virtual channels (VC_REQ, VC_RSP, VC_DAT, VC_SNP).
//   Holds per-VC downstream credit counters, picks one eligible VC per cycle with round-robin (optional RSP
//   priority) and registers the winning flit onto the link. Sits between router VC input buffers and the link.
// PARAMETERS
//   FLIT_W        default $bits(coh_noc_pkg::flit_u)        width of one flit
//   CREDIT_W      default coh_noc_pkg::CREDIT_COUNT_WIDTH (8)   credit counter width
//   INIT_CREDITS  default coh_noc_pkg::VC_BUFFER_DEPTH (16)    credits per VC after reset; must be 1..2^CREDIT_W-1
//   RSP_PRIO      default 0     1 = VC_RSP wins whenever eligible; 0 = pure round-robin
// PORTS
//   clk        in   1            clock; all logic on rising edge
//   rst_n      in   1            asynchronous, active-low reset
//   in_valid   in   4            per-VC flit available, index = virtual_channel_e value
//   in_flit    in   4*FLIT_W     per-VC flit; VC v occupies bits [v*FLIT_W +: FLIT_W]
//   in_ready   out  4            per-VC grant; flit v consumed when in_valid[v] && in_ready[v]
//   crd_rtn    in   4            per-VC credit return pulse, one credit per asserted bit per cycle
//   out_valid  out  1            link flit valid
//   out_vc     out  2            VC of out_flit (virtual_channel_e encoding)
//   out_flit   out  FLIT_W       link flit
//   crd_cnt    out  4*CREDIT_W   current credit count per VC, same packing as in_flit
//   crd_err    out  1            sticky credit-overflow error
// BEHAVIOUR
//   Reset (async assert, sync-released use): out_valid=0, out_vc=0, out_flit=0, crd_err=0, every crd_cnt=INIT_CREDITS,
//     rr_ptr=0. in_ready is combinational and reads 0 while crd_cnt values are at reset with no in_valid.
//   Eligibility: elig[v] = in_valid[v] && (crd_cnt[v] != 0).
//   Selection (combinational, same cycle): if RSP_PRIO && elig[1] -> grant VC1; else first elig VC scanning
//     rr_ptr, rr_ptr+1, ... mod 4. At most one in_ready bit high; in_ready[v] is never high unless in_valid[v].
//   rr_ptr: on any grant, rr_ptr <= (granted VC + 1) mod 4, including RSP_PRIO grants; unchanged if no grant.
//   Output register, latency 1: grant in cycle N -> cycle N+1 out_valid=1, out_vc=v, out_flit=in_flit[v].
//     No grant in cycle N -> out_valid=0 in N+1, out_vc/out_flit hold previous values. No back-pressure on link.
//   Throughput: one flit per cycle; a single VC may send every cycle while it has credits.
//   Credits: crd_cnt[v] next = crd_cnt[v] - grant[v] + crd_rtn[v].
//     grant and return same cycle -> unchanged. Count 0 -> VC ineligible; return at 0 makes it eligible next cycle.
//     Return when crd_cnt[v]==INIT_CREDITS (without same-cycle grant) -> counter saturates at INIT_CREDITS,
//     crd_err <= 1 and stays 1 until rst_n. Counter never wraps below 0 (grant impossible at 0).
//   Mid-operation reset: all state returns to reset values immediately; in-flight flit in output register dropped.
//   in_flit/in_valid are not required to be stable when not granted; requester may withdraw in_valid.
// TESTING
//   T1 reset: hold rst_n=0 -> out_valid=0, crd_err=0, each crd_cnt=16; release, no inputs -> all in_ready=0.
//   T2 round-robin, RSP_PRIO=0: in_valid=4'b1111 for 8 cycles -> in_ready 0001,0010,0100,1000 repeating;
//      out_vc 0,1,2,3,0,1,2,3 one cycle later, out_flit matching each source flit.
//   T3 exhaustion: only in_valid[2]=1 for 20 cycles, no crd_rtn -> 16 consecutive out_valid flits with out_vc=2,
//      crd_cnt[2]=0, in_ready[2]=0 thereafter; one crd_rtn[2] pulse -> exactly one more flit, count back to 0.
//   T4 simultaneous: VC0 count 10, in_valid[0]=1 and crd_rtn[0]=1 same cycle (only requester) -> grant, count stays 10.
//   T5 overflow: idle, crd_rtn[3] pulse at count 16 -> crd_cnt[3]=16, crd_err=1; stays 1 through traffic until rst_n.
//   T6 RSP_PRIO=1: in_valid=4'b1111 -> VC1 granted every cycle; drop in_valid[1] -> grants resume at VC2,3,0.

Source files
------------

// File: rtl/vc_credit_arbiter.sv
// Output-port scheduler for one four-VC NoC link: per-VC credit counters, round-robin
// (optionally RSP-first) selection and a registered link flit stage.
module vc_credit_arbiter #(
   parameter int FLIT_W       = 32,
   parameter int CREDIT_W     = 8,
   parameter int INIT_CREDITS = 16,
   parameter int RSP_PRIO     = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [3:0]            in_valid,
   input  logic [4*FLIT_W-1:0]   in_flit,
   output logic [3:0]            in_ready,
   input  logic [3:0]            crd_rtn,
   output logic                  out_valid,
   output logic [1:0]            out_vc,
   output logic [FLIT_W-1:0]     out_flit,
   output logic [4*CREDIT_W-1:0] crd_cnt,
   output logic                  crd_err
);

   localparam logic [CREDIT_W-1:0] CRD_MAX = CREDIT_W'(INIT_CREDITS);

   logic [CREDIT_W-1:0] crd_q [4];
   logic [1:0]          rr_ptr;
   logic [3:0]          elig;
   logic [3:0]          grant;
   logic [1:0]          grant_vc;
   logic [1:0]          scan_idx;
   logic                found;

   always_comb begin
      for (int v = 0; v < 4; v++) begin
         elig[v] = in_valid[v] && (crd_q[v] != '0);
         crd_cnt[v*CREDIT_W +: CREDIT_W] = crd_q[v];
      end
   end

   // Scan starts at rr_ptr so the VC after the last winner gets first look.
   always_comb begin
      grant    = '0;
      found    = 1'b0;
      scan_idx = rr_ptr;
      if ((RSP_PRIO != 0) && elig[1]) begin
         grant[1] = 1'b1;
      end else begin
         for (int i = 0; i < 4; i++) begin
            scan_idx = rr_ptr + 2'(i);
            if (!found && elig[scan_idx]) begin
               grant[scan_idx] = 1'b1;
               found           = 1'b1;
            end
         end
      end
   end

   always_comb begin
      grant_vc = 2'd0;
      for (int v = 0; v < 4; v++) begin
         if (grant[v]) grant_vc = 2'(v);
      end
   end

   assign in_ready = grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_vc    <= 2'd0;
         out_flit  <= '0;
         rr_ptr    <= 2'd0;
      end else if (grant != 4'd0) begin
         out_valid <= 1'b1;
         out_vc    <= grant_vc;
         out_flit  <= in_flit[int'(grant_vc)*FLIT_W +: FLIT_W];
         rr_ptr    <= grant_vc + 2'd1;
      end else begin
         out_valid <= 1'b0;
      end
   end

   // A return arriving with the counter already full saturates and latches the error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int v = 0; v < 4; v++) crd_q[v] <= CRD_MAX;
         crd_err <= 1'b0;
      end else begin
         for (int v = 0; v < 4; v++) begin
            if (grant[v] && !crd_rtn[v]) begin
               crd_q[v] <= crd_q[v] - 1'b1;
            end else if (!grant[v] && crd_rtn[v]) begin
               if (crd_q[v] == CRD_MAX) crd_err <= 1'b1;
               else                     crd_q[v] <= crd_q[v] + 1'b1;
            end
         end
      end
   end

endmodule
